// File: rtl/controlador_notas_if.sv
// rtl/controlador_notas_if.sv - key request / wavetable control bundle for controlador_notas
interface controlador_notas_if;
  logic [3:0] teclas;   // key requests, bit k = key k held
  logic       prox;     // sample-step strobe
  logic       play;     // playback enable
  logic [1:0] nota;     // granted key index
  logic       ocupado;  // controller not idle

  modport master (
    output teclas,
    input  prox,
    input  play,
    input  nota,
    input  ocupado
  );

  modport slave (
    input  teclas,
    output prox,
    output play,
    output nota,
    output ocupado
  );
endinterface

// File: rtl/controlador_notas.sv
// rtl/controlador_notas.sv - key-to-wavetable note controller; optional SYNC_TECLAS_EN adds a 2-flop key synchronizer
module controlador_notas #(
  parameter int DIV_LARG = 16,
  parameter int DIV0     = 400,
  parameter int DIV1     = 357,
  parameter int DIV2     = 318,
  parameter int DIV3     = 300
) (
  input logic             clk,
  input logic             rst_n,
  controlador_notas_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO,
    REINICIA,
    TOCANDO,
    LIBERA,
    ZERA
  } estado_t;

  // Reload value is period-1; periods below 2 are clamped so the strobe never fires back to back.
  function automatic logic [DIV_LARG-1:0] recarga(input int div);
    int per;
    per = (div < 2) ? 2 : div;
    return DIV_LARG'(per - 1);
  endfunction

  localparam logic [DIV_LARG-1:0] REC0 = recarga(DIV0);
  localparam logic [DIV_LARG-1:0] REC1 = recarga(DIV1);
  localparam logic [DIV_LARG-1:0] REC2 = recarga(DIV2);
  localparam logic [DIV_LARG-1:0] REC3 = recarga(DIV3);

  estado_t             estado;
  logic [DIV_LARG-1:0] cnt;
  logic [DIV_LARG-1:0] rec_sel;
  logic [3:0]          teclas_f;
  logic [1:0]          menor;

`ifdef SYNC_TECLAS_EN
  logic [3:0] sync1;
  logic [3:0] sync2;

  // Two-stage synchronizer for the asynchronous key inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.teclas;
      sync2 <= sync1;
    end
  end

  assign teclas_f = sync2;
`else
  assign teclas_f = bus.teclas;
`endif

  // Lowest set key index wins a fresh grant.
  always_comb begin
    menor = 2'd0;
    if (teclas_f[0])      menor = 2'd0;
    else if (teclas_f[1]) menor = 2'd1;
    else if (teclas_f[2]) menor = 2'd2;
    else if (teclas_f[3]) menor = 2'd3;
  end

  // Step period of the currently granted key.
  always_comb begin
    rec_sel = REC0;
    case (bus.nota)
      2'd0:    rec_sel = REC0;
      2'd1:    rec_sel = REC1;
      2'd2:    rec_sel = REC2;
      default: rec_sel = REC3;
    endcase
  end

  // Controller FSM; every output is set on the transition into the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      cnt         <= '0;
      bus.prox    <= 1'b0;
      bus.play    <= 1'b0;
      bus.nota    <= 2'd0;
      bus.ocupado <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          bus.play <= 1'b0;
          if (|teclas_f) begin
            bus.nota    <= menor;
            bus.prox    <= 1'b1;
            bus.ocupado <= 1'b1;
            estado      <= REINICIA;
          end else begin
            bus.prox    <= 1'b0;
            bus.ocupado <= 1'b0;
          end
        end
        REINICIA: begin
          cnt         <= rec_sel;
          bus.prox    <= 1'b0;
          bus.play    <= 1'b1;
          bus.ocupado <= 1'b1;
          estado      <= TOCANDO;
        end
        TOCANDO: begin
          bus.ocupado <= 1'b1;
          // Release has priority so a pending step strobe is dropped.
          if (!teclas_f[bus.nota]) begin
            bus.prox <= 1'b0;
            bus.play <= 1'b0;
            estado   <= LIBERA;
          end else if (cnt == '0) begin
            cnt      <= rec_sel;
            bus.prox <= 1'b0;
          end else if (cnt == DIV_LARG'(1)) begin
            cnt      <= '0;
            bus.prox <= 1'b1;
          end else begin
            cnt      <= cnt - 1'b1;
            bus.prox <= 1'b0;
          end
        end
        LIBERA: begin
          // Final strobe with play low drives the instrument output to zero.
          bus.prox    <= 1'b1;
          bus.play    <= 1'b0;
          bus.ocupado <= 1'b1;
          estado      <= ZERA;
        end
        ZERA: begin
          bus.prox    <= 1'b0;
          bus.play    <= 1'b0;
          bus.ocupado <= 1'b0;
          estado      <= OCIOSO;
        end
        default: begin
          bus.prox    <= 1'b0;
          bus.play    <= 1'b0;
          bus.ocupado <= 1'b0;
          estado      <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_notas.sv
// tb/tb_controlador_notas.sv - self-checking bench for controlador_notas
module tb_controlador_notas;

  localparam int P0 = 4;
  localparam int P1 = 5;
  localparam int P2 = 3;
  localparam int P3 = 1;
`ifdef SYNC_TECLAS_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  controlador_notas_if bus ();

  controlador_notas #(
    .DIV_LARG(16), .DIV0(P0), .DIV1(P1), .DIV2(P2), .DIV3(P3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  logic       log_prox [0:2047];
  logic       log_play [0:2047];
  logic       log_busy [0:2047];
  logic [1:0] log_nota [0:2047];

  // Expected outputs of the behavioural model
  logic       exp_prox = 1'b0;
  logic       exp_play = 1'b0;
  logic       exp_busy = 1'b0;
  logic [1:0] exp_nota = 2'd0;

  function automatic int periodo(input int k);
    int d;
    case (k)
      0: d = P0;
      1: d = P1;
      2: d = P2;
      default: d = P3;
    endcase
    return (d < 2) ? 2 : d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle log of DUT outputs for the hand-computed checks
  initial forever begin
    @(negedge clk);
    if (cyc < 2048) begin
      log_prox[cyc] = bus.prox;
      log_play[cyc] = bus.play;
      log_busy[cyc] = bus.ocupado;
      log_nota[cyc] = bus.nota;
    end
  end

  // Behavioural model: note lifecycle in terms of what the instrument sees
  initial begin : model
    int   mode;   // 0 idle, 1 restart pulse shown, 2 playing, 3 released, 4 zero pulse shown
    int   key;
    int   t;      // cycles since play went high
    logic [3:0] s1, s2, tk;
    mode = 0; key = 0; t = 0; s1 = '0; s2 = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mode = 0; t = 0; s1 = '0; s2 = '0;
        exp_prox = 0; exp_play = 0; exp_busy = 0; exp_nota = 0;
      end else begin
        if (L == 2) begin
          tk = s2; s2 = s1; s1 = bus.teclas;
        end else begin
          tk = bus.teclas;
        end
        case (mode)
          0: begin
            exp_prox = 0; exp_play = 0; exp_busy = 0;
            if (tk != 0) begin
              key = tk[0] ? 0 : tk[1] ? 1 : tk[2] ? 2 : 3;
              exp_nota = 2'(key);
              exp_prox = 1; exp_busy = 1;
              mode = 1;
            end
          end
          1: begin
            exp_prox = 0; exp_play = 1; t = 0; mode = 2;
          end
          2: begin
            if (!tk[key]) begin
              exp_prox = 0; exp_play = 0; mode = 3;
            end else begin
              t++;
              exp_prox = ((t % periodo(key)) == periodo(key) - 1);
            end
          end
          3: begin
            exp_prox = 1; exp_play = 0; mode = 4;
          end
          default: begin
            exp_prox = 0; exp_play = 0; exp_busy = 0; mode = 0;
          end
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("prox", bus.prox, exp_prox);
      chk("play", bus.play, exp_play);
      chk("ocupado", bus.ocupado, exp_busy);
      chk("nota", bus.nota, exp_nota);
    end
  end

  initial begin : stim
    int c0;
    int cr;
    rst_n = 1'b0;
    bus.teclas = 4'b0000;
    go(2);
    chk("reset_prox", bus.prox, 0);
    chk("reset_play", bus.play, 0);
    chk("reset_nota", bus.nota, 0);
    chk("reset_ocupado", bus.ocupado, 0);
    chk_on = 1'b1;
    rst_n = 1'b1;
    go(3);

    // Key 0, period 4, release lined up with a counter expiry
    c0 = cyc;
    bus.teclas = 4'b0001;
    go(16);
    bus.teclas = 4'b0000;
    go(8);
    for (int c = 0; c <= 16; c++) begin
      chk("k0_prox", log_prox[c0 + c],
          (c == 1 + L) || (c >= 5 + L && ((c - 5 - L) % 4) == 0));
      chk("k0_play", log_play[c0 + c], c >= 2 + L);
    end
    chk("rel_prox_dropped", log_prox[c0 + 17 + L], 0);
    chk("rel_play_low", log_play[c0 + 17 + L], 0);
    chk("zera_prox", log_prox[c0 + 18 + L], 1);
    chk("zera_play", log_play[c0 + 18 + L], 0);
    chk("after_zera_idle", log_busy[c0 + 19 + L], 0);
    chk("after_zera_prox", log_prox[c0 + 19 + L], 0);

    // Key 2 held, key 0 pressed later must not preempt
    c0 = cyc;
    bus.teclas = 4'b0100;
    go(10);
    bus.teclas = 4'b0101;
    go(10);
    chk("no_preempt_nota", bus.nota, 2);
    cr = cyc;
    bus.teclas = 4'b0001;
    go(8);
    chk("hand_zera", log_prox[cr + 2 + L], 1);
    chk("hand_idle", log_busy[cr + 3 + L], 0);
    chk("hand_regrant_prox", log_prox[cr + 4 + L], 1);
    chk("hand_regrant_nota", log_nota[cr + 4 + L], 0);
    bus.teclas = 4'b0000;
    go(8);

    // Simultaneous keys 1 and 3: lowest wins
    bus.teclas = 4'b1010;
    go(4);
    chk("simul_nota", bus.nota, 1);
    go(12);
    bus.teclas = 4'b0000;
    go(6);

    // Key 3 with DIV below 2 clamps to a period of 2
    c0 = cyc;
    bus.teclas = 4'b1000;
    go(10);
    chk("clamp_first", log_prox[c0 + 3 + L], 1);
    chk("clamp_gap", log_prox[c0 + 4 + L], 0);
    chk("clamp_second", log_prox[c0 + 5 + L], 1);
    bus.teclas = 4'b0000;
    go(6);

    // Key pulse shorter than REINICIA: release only seen in TOCANDO
    c0 = cyc;
    bus.teclas = 4'b0010;
    go(1);
    bus.teclas = 4'b0000;
    go(8);
    chk("pulse_play", log_play[c0 + 2 + L], 1);
    chk("pulse_zera", log_prox[c0 + 4 + L], 1);

    // Asynchronous reset mid-playback
    bus.teclas = 4'b0001;
    go(8);
    chk("pre_reset_play", bus.play, 1);
    rst_n = 1'b0;
    #1;
    chk("async_play", bus.play, 0);
    chk("async_prox", bus.prox, 0);
    chk("async_ocupado", bus.ocupado, 0);
    bus.teclas = 4'b0000;
    go(2);
    rst_n = 1'b1;
    go(5);
    chk("post_reset_idle", bus.ocupado, 0);
    chk("post_reset_prox", bus.prox, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlador_notas.md
CONTROLADOR_NOTAS -- requirements
Module: controlador_notas

Interface
REQ-001 The block SHALL have parameter DIV_LARG, default 16, meaning the width of the sample-step divider.
REQ-002 The block SHALL have parameters DIV0, DIV1, DIV2, DIV3, defaults 400, 357, 318, 300, meaning the clock cycles per sample step for keys 0..3.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port teclas, input, 4 bits: key requests, level-sensitive, bit k = key k held.
REQ-006 The block SHALL have port prox, output, 1 bit: sample-step strobe to the wavetable instrument, one-cycle pulse.
REQ-007 The block SHALL have port play, output, 1 bit: playback enable to the wavetable instrument.
REQ-008 The block SHALL have port nota, output, 2 bits: index of the granted key.
REQ-009 The block SHALL have port ocupado, output, 1 bit: high whenever the state is not OCIOSO.

Function
REQ-010 All outputs SHALL be registered.
REQ-011 The FSM SHALL have states OCIOSO, REINICIA, TOCANDO, LIBERA and ZERA.
REQ-012 OCIOSO: play=0, prox=0; if teclas!=0, grant the lowest set index, latch it into nota, and go to REINICIA.
REQ-013 REINICIA (1 cycle): prox=1, play=0 (zeroes the instrument index); load the counter with DIVk-1; go to TOCANDO.
REQ-014 TOCANDO: play=1; the counter decrements each cycle; at count 0, prox=1 for that cycle and the counter reloads DIVk-1.
REQ-015 The grant SHALL hold while the granted key stays set; a lower-index press SHALL NOT preempt.
REQ-016 Granted key released in TOCANDO: go to LIBERA with play=0, prox=0. Release SHALL win over a same-cycle counter expiry, so no prox is issued.
REQ-017 LIBERA (1 cycle) SHALL go to ZERA; ZERA (1 cycle) asserts prox=1 with play=0 (instrument output to 0), then goes to OCIOSO.
REQ-018 prox SHALL never be high in a cycle in which play changes value; play is stable at least one cycle before each prox rise.
REQ-019 A DIVk value below 2 SHALL be treated as 2; the counter is DIV_LARG bits wide and never wraps below 0.
REQ-020 Key changes during REINICIA, LIBERA or ZERA SHALL be ignored until the state that samples teclas next.

Reset
REQ-021 While rst_n=0: state=OCIOSO, counter=0, prox=0, play=0, nota=0, ocupado=0, taking effect immediately without a clock.
REQ-022 Reset during TOCANDO SHALL drop play and prox asynchronously; no ZERA pulse is issued.

Configuration
REQ-023 Macro SYNC_TECLAS_EN: when defined, teclas SHALL pass through a 2-flop synchronizer (reset 0) before the FSM, adding 2 cycles to every key-to-response latency.
REQ-024 Without SYNC_TECLAS_EN, the FSM SHALL sample teclas directly; all latencies below assume this case.

Verification
REQ-025 DIV0=4, teclas=0001 at cycle 0: REINICIA prox at cycle 1, play=1 from cycle 2, prox at cycles 5, 9, 13 ...
REQ-026 Key 2 held, then key 0 pressed: nota stays 2 and prox keeps the DIV2 period; after key 2 is released, LIBERA -> ZERA -> OCIOSO, then key 0 is granted with a fresh REINICIA pulse.
REQ-027 teclas=1010 pressed simultaneously: nota=1 and the DIV1 period is used.
REQ-028 Release in the same cycle as counter expiry: no prox that cycle; play=0 the next cycle; exactly one prox in ZERA.
REQ-029 rst_n pulled low mid-TOCANDO: play and prox go to 0 before the next clock edge; after release, the block is idle until a key is pressed.
REQ-030 With SYNC_TECLAS_EN defined, repeat REQ-025: REINICIA prox at cycle 3, play from cycle 4.
